// File: rtl/defender_pkg.sv
// defender_pkg: screen geometry, sprite sizes, colours and bullet state encoding for the scene renderer
package defender_pkg;
  localparam int H_ACTIVE_START = 144;
  localparam int V_ACTIVE_START = 36;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 479;
  localparam int SHIP_W = 32;
  localparam int SHIP_H = 16;
  localparam int SHIP_X0 = 64;
  localparam int SHIP_Y0 = 232;
  localparam int SHIP_STEP = 4;
  localparam int BULLET_W = 8;
  localparam int BULLET_H = 2;
  localparam int BULLET_STEP = 12;
  localparam logic [23:0] COL_BG = 24'h000020;
  localparam logic [23:0] COL_SHIP = 24'hFFFFFF;
  localparam logic [23:0] COL_BULLET = 24'hFFFF00;
  typedef enum logic {ST_IDLE, ST_FLYING} bullet_st_e;
  function automatic logic in_box(logic [10:0] p, logic [10:0] lo, logic [10:0] len);
    return p >= lo && p < lo + len;
  endfunction
endpackage

// File: rtl/defender_scene_renderer_if.sv
// defender_scene_renderer_if: timing-generator inputs, buttons and VGA outputs of the scene renderer
interface defender_scene_renderer_if;
  logic [9:0] H_COUNT, V_COUNT;
  logic HS_IN, VS_IN, BLANK_N_IN;
  logic BTN_UP, BTN_DOWN, BTN_FIRE;
  logic [7:0] VGA_R, VGA_G, VGA_B;
  logic VGA_HS, VGA_VS, VGA_BLANK_N;
  logic FRAME_TICK, BULLET_ACTIVE;
  modport master (
    output H_COUNT, V_COUNT, HS_IN, VS_IN, BLANK_N_IN, BTN_UP, BTN_DOWN, BTN_FIRE,
    input VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, FRAME_TICK, BULLET_ACTIVE
  );
  modport slave (
    input H_COUNT, V_COUNT, HS_IN, VS_IN, BLANK_N_IN, BTN_UP, BTN_DOWN, BTN_FIRE,
    output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, FRAME_TICK, BULLET_ACTIVE
  );
endinterface

// File: rtl/defender_scene_renderer_button_sync.sv
// button_sync: two-flop synchroniser for a raw button plus a rising-edge pulse on the synchronised level
module button_sync (
  input  logic CLK,
  input  logic RST,
  input  logic btn,
  output logic level,
  output logic rise
);
  logic [2:0] s_q, s_d;
  always_comb s_d = {s_q[1:0], btn};
  always_ff @(posedge CLK or posedge RST)
    if (RST) s_q <= '0;
    else s_q <= s_d;
  assign level = s_q[1];
  assign rise = s_q[1] & ~s_q[2];
endmodule

// File: rtl/defender_scene_renderer.sv
// defender_scene_renderer: per-frame ship/bullet state from buttons and a registered RGB pixel stage
module defender_scene_renderer
  import defender_pkg::*;
(
  input logic CLK,
  input logic RST,
  defender_scene_renderer_if.slave bus
);
  logic up, dn, fire_rise, unused_up_rise, unused_dn_rise, unused_fire_level;
  logic tick_q, tick_d, fire_req_q, fire_req_d;
  logic [9:0] ship_y_q, ship_y_d, bx_q, bx_d, by_q, by_d;
  bullet_st_e st_q, st_d;
  logic [23:0] rgb_q, rgb_d;
  logic [2:0] sync_q, sync_d;
  logic [10:0] y11, up_y, dn_y, bx_next, px, py;
  logic launch, leave, on, hit_b, hit_s;

  button_sync u_up (.CLK(CLK), .RST(RST), .btn(bus.BTN_UP), .level(up), .rise(unused_up_rise));
  button_sync u_dn (.CLK(CLK), .RST(RST), .btn(bus.BTN_DOWN), .level(dn), .rise(unused_dn_rise));
  button_sync u_fire (.CLK(CLK), .RST(RST), .btn(bus.BTN_FIRE), .level(unused_fire_level), .rise(fire_rise));

  always_comb begin
    tick_d = bus.H_COUNT == 10'd0 && bus.V_COUNT == 10'(V_ACTIVE_START + SCREEN_H);
    // an edge arriving on the tick cycle survives the clear and launches on the next tick
    fire_req_d = (tick_q ? 1'b0 : fire_req_q) | fire_rise;
    y11 = {1'b0, ship_y_q};
    up_y = y11 < 11'(SHIP_STEP) ? 11'd0 : y11 - 11'(SHIP_STEP);
    dn_y = y11 + 11'(SHIP_STEP) > 11'(SCREEN_H - SHIP_H) ? 11'(SCREEN_H - SHIP_H) : y11 + 11'(SHIP_STEP);
    ship_y_d = !tick_q || up == dn ? ship_y_q : up ? up_y[9:0] : dn_y[9:0];
    bx_next = {1'b0, bx_q} + 11'(BULLET_STEP);
    leave = bx_next >= 11'(SCREEN_W);
    launch = tick_q && st_q == ST_IDLE && fire_req_q;
    st_d = !tick_q ? st_q : st_q == ST_IDLE ? (fire_req_q ? ST_FLYING : ST_IDLE) : (leave ? ST_IDLE : ST_FLYING);
    bx_d = launch ? 10'(SHIP_X0 + SHIP_W) : tick_q && st_q == ST_FLYING && !leave ? bx_next[9:0] : bx_q;
    by_d = launch ? ship_y_q + 10'(SHIP_H / 2 - 1) : by_q;
    px = {1'b0, bus.H_COUNT} - 11'(H_ACTIVE_START);
    py = {1'b0, bus.V_COUNT} - 11'(V_ACTIVE_START);
    on = !px[10] && !py[10] && px < 11'(SCREEN_W) && py < 11'(SCREEN_H);
    hit_b = on && st_q == ST_FLYING && in_box(px, {1'b0, bx_q}, 11'(BULLET_W)) && in_box(py, {1'b0, by_q}, 11'(BULLET_H));
    hit_s = on && in_box(px, 11'(SHIP_X0), 11'(SHIP_W)) && in_box(py, y11, 11'(SHIP_H));
    rgb_d = !bus.BLANK_N_IN ? 24'd0 : hit_b ? COL_BULLET : hit_s ? COL_SHIP : COL_BG;
    sync_d = {bus.HS_IN, bus.VS_IN, bus.BLANK_N_IN};
  end

  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      tick_q <= 1'b0;
      fire_req_q <= 1'b0;
      ship_y_q <= 10'(SHIP_Y0);
      st_q <= ST_IDLE;
      bx_q <= '0;
      by_q <= '0;
      rgb_q <= '0;
      sync_q <= '0;
    end else begin
      tick_q <= tick_d;
      fire_req_q <= fire_req_d;
      ship_y_q <= ship_y_d;
      st_q <= st_d;
      bx_q <= bx_d;
      by_q <= by_d;
      rgb_q <= rgb_d;
      sync_q <= sync_d;
    end

  assign {bus.VGA_R, bus.VGA_G, bus.VGA_B} = rgb_q;
  assign {bus.VGA_HS, bus.VGA_VS, bus.VGA_BLANK_N} = sync_q;
  assign bus.FRAME_TICK = tick_q;
  assign bus.BULLET_ACTIVE = st_q == ST_FLYING;
endmodule

// File: tb/tb_defender_scene_renderer.sv
// tb_defender_scene_renderer: randomized frames checked by a scoreboard against a game-level reference model
module tb_defender_scene_renderer;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  defender_scene_renderer_if bus ();
  defender_scene_renderer dut (.CLK(CLK), .RST(RST), .bus(bus));

  int errors = 0, checks = 0;
  logic [28:0] q[$];
  int my, mbx, mby;
  bit mfly, mreq, mtick, release_pending;
  bit [2:0] hu, hd, hf;

  function automatic void check(string name, logic [28:0] act, logic [28:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got rgb=%h hs/vs/bn=%b tick=%b act=%b, expected rgb=%h hs/vs/bn=%b tick=%b act=%b",
               name, act[28:5], act[4:2], act[1], act[0], exp[28:5], exp[4:2], exp[1], exp[0]);
    end
  endfunction

  function automatic logic [28:0] outs();
    return {bus.VGA_R, bus.VGA_G, bus.VGA_B, bus.VGA_HS, bus.VGA_VS, bus.VGA_BLANK_N, bus.FRAME_TICK, bus.BULLET_ACTIVE};
  endfunction

  function automatic logic [23:0] mcol(int px, int py, bit bn);
    if (!bn) return 24'h0;
    if (px < 0 || py < 0 || px >= 640 || py >= 479) return 24'h000020;
    if (mfly && px >= mbx && px < mbx + 8 && py >= mby && py < mby + 2) return 24'hFFFF00;
    if (px >= 64 && px < 96 && py >= my && py < my + 16) return 24'hFFFFFF;
    return 24'h000020;
  endfunction

  function automatic void model_reset();
    my = 232; mfly = 0; mreq = 0; mtick = 0; mbx = 0; mby = 0;
    hu = 0; hd = 0; hf = 0;
  endfunction

  task automatic step(int px, int py, bit bn, bit up, bit dn, bit fire);
    logic [9:0] h, v;
    bit hs, vs, lu, ld, rf;
    logic [23:0] c;
    @(negedge CLK);
    h = 10'(px + 144);
    v = 10'(py + 36);
    hs = 1'($urandom);
    vs = 1'($urandom);
    bus.H_COUNT = h; bus.V_COUNT = v; bus.HS_IN = hs; bus.VS_IN = vs; bus.BLANK_N_IN = bn;
    bus.BTN_UP = up; bus.BTN_DOWN = dn; bus.BTN_FIRE = fire;
    if (release_pending) begin RST = 1'b0; release_pending = 0; end
    c = mcol(int'(h) - 144, int'(v) - 36, bn);
    lu = hu[1]; ld = hd[1]; rf = hf[1] & ~hf[2];
    if (mtick) begin
      if (!mfly) begin
        if (mreq) begin mfly = 1; mbx = 96; mby = my + 7; end
      end else if (mbx + 12 >= 640) mfly = 0;
      else mbx += 12;
      if (lu && !ld) my = (my < 4) ? 0 : my - 4;
      else if (ld && !lu) my = (my + 4 > 463) ? 463 : my + 4;
      mreq = rf;
    end else mreq = mreq | rf;
    mtick = (h == 0 && v == 515);
    hu = {hu[1:0], up}; hd = {hd[1:0], dn}; hf = {hf[1:0], fire};
    q.push_back({c, hs, vs, bn, mtick, mfly});
  endtask

  task automatic frame(bit up, bit dn, int mode);
    int y, bx, by;
    step(10, 10, 1, up, dn, mode == 2);
    step(-144, 479, 0, up, dn, 0);
    step(20, 20, 1, up, dn, 0);
    y = my;
    step(64, y, 1, up, dn, 0); step(95, y + 15, 1, up, dn, 0); step(96, y, 1, up, dn, 0);
    step(63, y, 1, up, dn, 0); step(64, y - 1, 1, up, dn, 0); step(64, y + 16, 1, up, dn, 0);
    if (mode == 1) step(300, 300, 1, up, dn, 1);
    if (mfly) begin
      bx = mbx; by = mby;
      step(bx, by, 1, up, dn, 0); step(bx + 7, by + 1, 1, up, dn, 0); step(bx + 8, by, 1, up, dn, 0);
      step(bx, by + 2, 1, up, dn, 0); step(bx - 1, by, 1, up, dn, 0);
    end
    for (int i = 0; i < 4; i++)
      step(int'($urandom_range(0, 799)) - 144, int'($urandom_range(0, 524)) - 36, 1'($urandom), up, dn, 0);
  endtask

  task automatic reset_mid_frame();
    @(negedge CLK);
    #2 RST = 1'b1;
    #1 check("async_reset", outs(), 29'd0);
    q.delete();
    model_reset();
    repeat (2) @(negedge CLK);
    release_pending = 1;
  endtask

  always @(posedge CLK) begin
    #1;
    if (!RST && q.size() > 0) check("pixel", outs(), q.pop_front());
  end

  initial begin
    bus.H_COUNT = 10'd1; bus.V_COUNT = 10'd0; bus.HS_IN = 0; bus.VS_IN = 0; bus.BLANK_N_IN = 0;
    bus.BTN_UP = 0; bus.BTN_DOWN = 0; bus.BTN_FIRE = 0;
    model_reset();
    repeat (3) @(negedge CLK);
    check("reset_state", outs(), 29'd0);
    release_pending = 1;
    repeat (2) frame(0, 0, 0);
    for (int x = 60; x < 100; x++) step(x, 240, 1, 0, 0, 0);
    for (int x = 205; x < 212; x++) step(x - 144, 232, 1, 0, 0, 0);
    repeat (60) frame(1, 0, 0);
    repeat (25) frame(0, 1, 0);
    frame(0, 0, 1);
    frame(0, 0, 1);
    repeat (3) frame(0, 0, 0);
    step(100, 100, 1, 0, 0, 0);
    reset_mid_frame();
    repeat (2) frame(0, 0, 0);
    frame(0, 0, 1);
    for (int i = 0; i < 50; i++) frame(i % 7 == 3, i % 5 == 1, (i == 10) ? 1 : 0);
    frame(0, 0, 2);
    repeat (3) frame(0, 0, 0);
    repeat (30) frame(1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    @(posedge CLK);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
